// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard: tracks destination tags of in-flight instructions from EX
// onward, drives EX operand forward selects, MEM store-data forwarding and load-use stalls.
module fwd_scoreboard #(
   parameter  int REG_W    = 4,
   parameter  int NUM_SRC  = 2,
   parameter  int DEPTH    = 2,
   parameter  int LD_AVAIL = 2,
   parameter  int CNT_W    = 16,
   localparam int SEL_W    = $clog2(DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     issue_vld,
   input  logic [REG_W-1:0]         issue_dst,
   input  logic                     issue_we,
   input  logic                     issue_ld,
   input  logic                     issue_st,
   input  logic [NUM_SRC*REG_W-1:0] issue_src,
   input  logic [NUM_SRC-1:0]       issue_src_vld,
   input  logic                     flush,
   output logic                     stall,
   output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
   output logic                     fwd_mem,
   output logic [CNT_W-1:0]         stall_cnt
);

   // Slot 0 is the instruction in EX; slot k is k stages later.
   logic                     slot_vld_q  [0:DEPTH];
   logic                     slot_vld_d  [0:DEPTH];
   logic [REG_W-1:0]         slot_dst_q  [0:DEPTH];
   logic [REG_W-1:0]         slot_dst_d  [0:DEPTH];
   logic                     slot_we_q   [0:DEPTH];
   logic                     slot_we_d   [0:DEPTH];
   logic                     slot_ld_q   [0:DEPTH];
   logic                     slot_ld_d   [0:DEPTH];
   logic                     slot_st_q   [0:DEPTH];
   logic                     slot_st_d   [0:DEPTH];
   logic [NUM_SRC*REG_W-1:0] slot_src_q  [0:DEPTH];
   logic [NUM_SRC*REG_W-1:0] slot_src_d  [0:DEPTH];
   logic [NUM_SRC-1:0]       slot_srcv_q [0:DEPTH];
   logic [NUM_SRC-1:0]       slot_srcv_d [0:DEPTH];

   logic [NUM_SRC*SEL_W-1:0] fwd_sel_q;
   logic [NUM_SRC*SEL_W-1:0] fwd_sel_d;
   logic                     fwd_mem_q;
   logic                     fwd_mem_d;
   logic [CNT_W-1:0]         stall_cnt_q;
   logic [CNT_W-1:0]         stall_cnt_d;
   logic                     hazard_s;
   logic                     stall_s;

   function automatic logic is_prod(input logic vld, input logic we, input logic [REG_W-1:0] dst);
      return vld & we & (dst != {REG_W{1'b0}});
   endfunction

   // Load-use hazard: youngest matching producer is a load whose data is not yet forwardable
   always_comb begin
      logic             hit;
      logic             hit_now;
      logic             late;
      logic             exempt;
      logic [REG_W-1:0] src;
      hazard_s = 1'b0;
      hit      = 1'b0;
      hit_now  = 1'b0;
      late     = 1'b0;
      exempt   = 1'b0;
      src      = {REG_W{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
         src = issue_src[i*REG_W +: REG_W];
         hit = 1'b0;
         for (int j = 0; j < DEPTH; j++) begin
            hit_now = ~hit & issue_src_vld[i]
                    & is_prod(slot_vld_q[j], slot_we_q[j], slot_dst_q[j])
                    & (slot_dst_q[j] == src);
            late    = (j + 1 < LD_AVAIL);
            // Store data from a load just ahead is picked up later by the MEM-to-MEM path.
            exempt  = (LD_AVAIL == 2) & (i == 1) & issue_st & (j == 0);
            hazard_s = hazard_s | (hit_now & slot_ld_q[j] & late & ~exempt);
            hit      = hit | hit_now;
         end
      end
      stall_s = hazard_s & issue_vld & ~flush;
   end

   // Next slot contents: shift everything down, load EX with the issuing instruction or a bubble
   always_comb begin
      for (int k = 1; k <= DEPTH; k++) begin
         slot_vld_d[k]  = slot_vld_q[k-1];
         slot_dst_d[k]  = slot_dst_q[k-1];
         slot_we_d[k]   = slot_we_q[k-1];
         slot_ld_d[k]   = slot_ld_q[k-1];
         slot_st_d[k]   = slot_st_q[k-1];
         slot_src_d[k]  = slot_src_q[k-1];
         slot_srcv_d[k] = slot_srcv_q[k-1];
      end
      if (issue_vld & ~stall_s & ~flush) begin
         slot_vld_d[0]  = 1'b1;
         slot_dst_d[0]  = issue_dst;
         slot_we_d[0]   = issue_we;
         slot_ld_d[0]   = issue_ld;
         slot_st_d[0]   = issue_st;
         slot_src_d[0]  = issue_src;
         slot_srcv_d[0] = issue_src_vld;
      end else begin
         slot_vld_d[0]  = 1'b0;
         slot_dst_d[0]  = {REG_W{1'b0}};
         slot_we_d[0]   = 1'b0;
         slot_ld_d[0]   = 1'b0;
         slot_st_d[0]   = 1'b0;
         slot_src_d[0]  = {(NUM_SRC*REG_W){1'b0}};
         slot_srcv_d[0] = {NUM_SRC{1'b0}};
      end
   end

   // Forward selects computed from next-state slots so the outputs come straight from flops
   always_comb begin
      logic             hit;
      logic             hit_now;
      logic [REG_W-1:0] src;
      logic [SEL_W-1:0] sel;
      fwd_sel_d = {(NUM_SRC*SEL_W){1'b0}};
      hit       = 1'b0;
      hit_now   = 1'b0;
      src       = {REG_W{1'b0}};
      sel       = {SEL_W{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
         src = slot_src_d[0][i*REG_W +: REG_W];
         hit = 1'b0;
         sel = {SEL_W{1'b0}};
         for (int k = 1; k <= DEPTH; k++) begin
            hit_now = ~hit & slot_vld_d[0] & slot_srcv_d[0][i]
                    & is_prod(slot_vld_d[k], slot_we_d[k], slot_dst_d[k])
                    & (slot_dst_d[k] == src);
            // A load whose data is not ready yet is never selected; the youngest match still blocks older ones.
            sel = hit_now ? ((slot_ld_d[k] && (k < LD_AVAIL)) ? {SEL_W{1'b0}} : SEL_W'(k)) : sel;
            hit = hit | hit_now;
         end
         fwd_sel_d[i*SEL_W +: SEL_W] = sel;
      end
      fwd_mem_d = slot_vld_d[1] & slot_st_d[1] & slot_srcv_d[1][1]
                & is_prod(slot_vld_d[2], slot_we_d[2], slot_dst_d[2])
                & (slot_dst_d[2] == slot_src_d[1][REG_W +: REG_W]);
   end

   // Saturating stall cycle counter
   always_comb begin
      if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k <= DEPTH; k++) begin
            slot_vld_q[k]  <= 1'b0;
            slot_dst_q[k]  <= {REG_W{1'b0}};
            slot_we_q[k]   <= 1'b0;
            slot_ld_q[k]   <= 1'b0;
            slot_st_q[k]   <= 1'b0;
            slot_src_q[k]  <= {(NUM_SRC*REG_W){1'b0}};
            slot_srcv_q[k] <= {NUM_SRC{1'b0}};
         end
         fwd_sel_q   <= {(NUM_SRC*SEL_W){1'b0}};
         fwd_mem_q   <= 1'b0;
         stall_cnt_q <= {CNT_W{1'b0}};
      end else begin
         for (int k = 0; k <= DEPTH; k++) begin
            slot_vld_q[k]  <= slot_vld_d[k];
            slot_dst_q[k]  <= slot_dst_d[k];
            slot_we_q[k]   <= slot_we_d[k];
            slot_ld_q[k]   <= slot_ld_d[k];
            slot_st_q[k]   <= slot_st_d[k];
            slot_src_q[k]  <= slot_src_d[k];
            slot_srcv_q[k] <= slot_srcv_d[k];
         end
         fwd_sel_q   <= fwd_sel_d;
         fwd_mem_q   <= fwd_mem_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall     = stall_s;
   assign fwd_sel   = fwd_sel_q;
   assign fwd_mem   = fwd_mem_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed vector table, reset/saturation sequences and a random
// run checked against a queue-based model of the in-flight instructions.
module tb_fwd_scoreboard;
   localparam int DEPTH    = 2;
   localparam int LD_AVAIL = 2;

   typedef struct packed {
      logic       vld;
      logic [3:0] dst;
      logic       we;
      logic       ld;
      logic       st;
      logic [3:0] s0;
      logic [3:0] s1;
      logic [1:0] sv;
   } ins_t;

   typedef struct packed {
      ins_t        in;
      logic        fl;
      logic        e_stall;
      logic [1:0]  e_sel0;
      logic [1:0]  e_sel1;
      logic        e_mem;
      logic [15:0] e_cnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_vld, issue_we, issue_ld, issue_st, flush;
   logic [3:0]  issue_dst;
   logic [7:0]  issue_src;
   logic [1:0]  issue_src_vld;
   logic        stall, stall_c2, fwd_mem, fwd_mem_c2;
   logic [3:0]  fwd_sel, fwd_sel_c2;
   logic [15:0] stall_cnt;
   logic [1:0]  stall_cnt_c2;

   int   tests_run = 0;
   int   tests_failed = 0;
   ins_t pipe[$];
   ins_t cur_in;
   logic cur_fl;
   logic m_stall, m_mem;
   int   m_sel[2];
   int   m_cnt16, m_cnt2;
   vec_t vecs[$];
   ins_t bub;

   always #5 clk = ~clk;

   fwd_scoreboard dut (
      .clk(clk), .rst_n(rst_n), .issue_vld(issue_vld), .issue_dst(issue_dst),
      .issue_we(issue_we), .issue_ld(issue_ld), .issue_st(issue_st), .issue_src(issue_src),
      .issue_src_vld(issue_src_vld), .flush(flush), .stall(stall), .fwd_sel(fwd_sel),
      .fwd_mem(fwd_mem), .stall_cnt(stall_cnt)
   );

   fwd_scoreboard #(.CNT_W(2)) dut_c2 (
      .clk(clk), .rst_n(rst_n), .issue_vld(issue_vld), .issue_dst(issue_dst),
      .issue_we(issue_we), .issue_ld(issue_ld), .issue_st(issue_st), .issue_src(issue_src),
      .issue_src_vld(issue_src_vld), .flush(flush), .stall(stall_c2), .fwd_sel(fwd_sel_c2),
      .fwd_mem(fwd_mem_c2), .stall_cnt(stall_cnt_c2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic ins_t mk(input int vld, input int dst, input int we, input int ld,
                               input int st, input int s0, input int s1, input int sv);
      ins_t r;
      r.vld = vld[0];  r.dst = dst[3:0]; r.we = we[0]; r.ld = ld[0]; r.st = st[0];
      r.s0  = s0[3:0]; r.s1  = s1[3:0]; r.sv = sv[1:0];
      return r;
   endfunction

   task automatic add(input ins_t in, input int fl, input int es, input int e0, input int e1,
                      input int em, input int ec);
      vec_t v;
      v.in = in; v.fl = fl[0]; v.e_stall = es[0]; v.e_sel0 = e0[1:0]; v.e_sel1 = e1[1:0];
      v.e_mem = em[0]; v.e_cnt = ec[15:0];
      vecs.push_back(v);
   endtask

   task automatic flush3(input int ec);
      for (int n = 0; n < 3; n++) add(bub, 0, 0, 0, 0, 0, ec);
   endtask

   // ---- reference model: pipe[k] is the instruction k stages past EX ----
   function automatic logic is_prod(input ins_t x);
      return x.vld && x.we && (x.dst != 4'd0);
   endfunction

   function automatic int find_prod(input int lo, input int hi, input logic [3:0] r);
      for (int k = lo; k <= hi; k++)
         if (is_prod(pipe[k]) && pipe[k].dst == r) return k;
      return -1;
   endfunction

   function automatic logic [3:0] src_of(input ins_t x, input int i);
      return (i == 1) ? x.s1 : x.s0;
   endfunction

   task automatic model_eval();
      int j;
      int k;
      m_stall = 1'b0;
      if (cur_in.vld && !cur_fl) begin
         for (int i = 0; i < 2; i++) begin
            if (cur_in.sv[i]) begin
               j = find_prod(0, DEPTH - 1, src_of(cur_in, i));
               if (j >= 0 && pipe[j].ld && (j + 1) < LD_AVAIL &&
                   !(LD_AVAIL == 2 && i == 1 && cur_in.st && j == 0))
                  m_stall = 1'b1;
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         m_sel[i] = 0;
         if (pipe[0].vld && pipe[0].sv[i]) begin
            k = find_prod(1, DEPTH, src_of(pipe[0], i));
            if (k > 0 && !(pipe[k].ld && k < LD_AVAIL)) m_sel[i] = k;
         end
      end
      m_mem = pipe[1].vld && pipe[1].st && pipe[1].sv[1] && is_prod(pipe[2]) &&
              (pipe[2].dst == pipe[1].s1);
   endtask

   task automatic model_step();
      if (m_stall) begin
         if (m_cnt16 < 65535) m_cnt16++;
         if (m_cnt2 < 3) m_cnt2++;
      end
      pipe.push_front((cur_in.vld && !m_stall && !cur_fl) ? cur_in : bub);
      void'(pipe.pop_back());
   endtask

   task automatic model_reset();
      pipe.delete();
      for (int n = 0; n <= DEPTH; n++) pipe.push_back(bub);
      m_cnt16 = 0;
      m_cnt2  = 0;
   endtask

   task automatic drive(input ins_t in, input logic fl);
      issue_vld = in.vld; issue_dst = in.dst; issue_we = in.we; issue_ld = in.ld;
      issue_st = in.st; issue_src = {in.s1, in.s0}; issue_src_vld = in.sv; flush = fl;
      cur_in = in; cur_fl = fl;
      #2;
      model_eval();
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      model_step();
   endtask

   initial begin
      ins_t r;
      logic fl;
      bub = mk(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      drive(bub, 1'b0);
      model_reset();
      #10;
      check("rst_stall", stall, 0);
      check("rst_fwd_sel", fwd_sel, 0);
      check("rst_fwd_mem", fwd_mem, 0);
      check("rst_cnt", stall_cnt, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // R3 producer, consumer held in ID for three cycles
      add(mk(1, 3, 1, 0, 0, 1, 2, 3), 0, 0, 0, 0, 0, 0);
      add(mk(1, 7, 0, 0, 0, 3, 3, 3), 0, 0, 0, 0, 0, 0);
      add(mk(1, 7, 0, 0, 0, 3, 3, 3), 0, 0, 1, 1, 0, 0);
      add(mk(1, 7, 0, 0, 0, 3, 3, 3), 0, 0, 2, 2, 0, 0);
      add(bub, 0, 0, 0, 0, 0, 0);
      flush3(0);
      // double producer of R5: youngest wins
      add(mk(1, 5, 1, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0);
      add(mk(1, 5, 1, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0);
      add(mk(1, 6, 1, 0, 0, 5, 0, 1), 0, 0, 0, 0, 0, 0);
      add(bub, 0, 0, 1, 0, 0, 0);
      flush3(0);
      // load-use: one stall cycle, then forward from slot 2
      add(mk(1, 4, 1, 1, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0);
      add(mk(1, 8, 1, 0, 0, 4, 0, 1), 0, 1, 0, 0, 0, 0);
      add(mk(1, 8, 1, 0, 0, 4, 0, 1), 0, 0, 0, 0, 0, 1);
      add(bub, 0, 0, 2, 0, 0, 1);
      flush3(1);
      // load then store of the loaded data: no stall, MEM-to-MEM forward
      add(mk(1, 4, 1, 1, 0, 0, 0, 0), 0, 0, 0, 0, 0, 1);
      add(mk(1, 0, 0, 0, 1, 2, 4, 3), 0, 0, 0, 0, 0, 1);
      add(bub, 0, 0, 0, 0, 0, 1);
      add(bub, 0, 0, 0, 0, 1, 1);
      flush3(1);
      // R0 writer never forwards; flushed consumer does not stall and becomes a bubble
      add(mk(1, 0, 1, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 1);
      add(mk(1, 7, 0, 0, 0, 0, 0, 1), 0, 0, 0, 0, 0, 1);
      add(bub, 0, 0, 0, 0, 0, 1);
      add(mk(1, 9, 1, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 1);
      add(mk(1, 4, 1, 1, 0, 0, 0, 0), 0, 0, 0, 0, 0, 1);
      add(mk(1, 7, 0, 0, 0, 4, 9, 3), 1, 0, 0, 0, 0, 1);
      add(bub, 0, 0, 0, 0, 0, 1);
      flush3(1);

      for (int n = 0; n < vecs.size(); n++) begin
         drive(vecs[n].in, vecs[n].fl);
         check($sformatf("vec%0d_stall", n), stall, vecs[n].e_stall);
         check($sformatf("vec%0d_sel0", n), fwd_sel[1:0], vecs[n].e_sel0);
         check($sformatf("vec%0d_sel1", n), fwd_sel[3:2], vecs[n].e_sel1);
         check($sformatf("vec%0d_mem", n), fwd_mem, vecs[n].e_mem);
         check($sformatf("vec%0d_cnt", n), stall_cnt, vecs[n].e_cnt);
         advance();
      end

      // reset dropped while a load-use stall is active
      drive(mk(1, 3, 1, 0, 0, 0, 0, 0), 1'b0); advance();
      drive(mk(1, 4, 1, 1, 0, 3, 0, 1), 1'b0); advance();
      drive(mk(1, 8, 1, 0, 0, 3, 4, 3), 1'b0);
      check("pre_rst_stall", stall, 1);
      check("pre_rst_sel0", fwd_sel[1:0], 1);
      check("pre_rst_cnt", stall_cnt, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_stall", stall, 0);
      check("mid_rst_fwd_sel", fwd_sel, 0);
      check("mid_rst_fwd_mem", fwd_mem, 0);
      check("mid_rst_cnt", stall_cnt, 0);
      check("mid_rst_cnt_c2", stall_cnt_c2, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();

      // back-to-back dependent loads: a stall every other cycle, five in total
      for (int n = 0; n < 10; n++) begin
         drive(mk(1, 4, 1, 1, 0, 4, 0, 1), 1'b0);
         check($sformatf("sat%0d_stall", n), stall, (n % 2 == 1) ? 1 : 0);
         advance();
      end
      drive(bub, 1'b0);
      check("sat_cnt16", stall_cnt, 5);
      check("sat_cnt2", stall_cnt_c2, 3);
      advance();

      // randomized run against the model
      for (int n = 0; n < 400; n++) begin
         r.vld = ($urandom_range(0, 7) != 0);
         r.dst = 4'($urandom_range(0, 5));
         r.we  = ($urandom_range(0, 3) != 0);
         r.ld  = ($urandom_range(0, 2) == 0);
         r.st  = !r.ld && ($urandom_range(0, 2) == 0);
         r.s0  = 4'($urandom_range(0, 5));
         r.s1  = 4'($urandom_range(0, 5));
         r.sv  = 2'($urandom_range(0, 3));
         fl    = ($urandom_range(0, 9) == 0);
         drive(r, fl);
         check("rnd_stall", stall, m_stall);
         check("rnd_sel0", fwd_sel[1:0], m_sel[0]);
         check("rnd_sel1", fwd_sel[3:2], m_sel[1]);
         check("rnd_mem", fwd_mem, m_mem);
         check("rnd_cnt", stall_cnt, m_cnt16);
         check("rnd_cnt_c2", stall_cnt_c2, m_cnt2);
         check("rnd_c2_outs", {stall_c2, fwd_sel_c2, fwd_mem_c2}, {m_stall, 2'(m_sel[1]), 2'(m_sel[0]), m_mem});
         for (int i = 0; i < 2; i++) begin
            int s;
            s = (i == 0) ? int'(fwd_sel[1:0]) : int'(fwd_sel[3:2]);
            check("rnd_no_early_load_fwd",
                  (s > 0 && s <= DEPTH && pipe[s].ld && s < LD_AVAIL) ? 1 : 0, 0);
         end
         advance();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
